seg7_sequence_tracker: RTL

- Receive-side counterpart of the decimal up/down counter's 7-segment encoder.
- Samples an 8-bit segment pattern and decodes it back to a digit 0-9.
- Tracks successive digits to infer count direction, counts steps and decade wraps, and flags illegal patterns and non-adjacent jumps.
- Sits between the SEG bus and the LCD debug outputs; it is also reused in benches as a display monitor.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_to_digit.sv | 30 +++
 rtl/seg7_sequence_tracker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, state type and mod-10 helpers for the 7-segment tracker slice.
package seg7_pkg;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

    typedef enum logic [1:0] {EMPTY, TRACK} trk_state_t;

    function automatic logic [3:0] inc10(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] dec10(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational 7-segment pattern decoder; exact match against the digit table.
module seg7_to_digit
    import seg7_pkg::*;
#(
    parameter int unsigned NBITS_SEG = 8
) (
    input  logic [NBITS_SEG-1:0] seg_in,
    output logic                 legal,
    output logic [3:0]           digit
);

    always_comb begin
        legal = 1'b1;
        digit = 4'd0;
        case (seg_in)
            NBITS_SEG'(SEG_0): digit = 4'd0;
            NBITS_SEG'(SEG_1): digit = 4'd1;
            NBITS_SEG'(SEG_2): digit = 4'd2;
            NBITS_SEG'(SEG_3): digit = 4'd3;
            NBITS_SEG'(SEG_4): digit = 4'd4;
            NBITS_SEG'(SEG_5): digit = 4'd5;
            NBITS_SEG'(SEG_6): digit = 4'd6;
            NBITS_SEG'(SEG_7): digit = 4'd7;
            NBITS_SEG'(SEG_8): digit = 4'd8;
            NBITS_SEG'(SEG_9): digit = 4'd9;
            default:           legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_sequence_tracker.sv
// Decodes sampled 7-segment patterns and tracks count direction, steps and decade wraps,
// flagging illegal patterns and non-adjacent jumps.
module seg7_sequence_tracker
    import seg7_pkg::*;
#(
    parameter int unsigned NBITS_SEG = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NBITS_SEG-1:0] seg_in,
    input  logic                 seg_valid,
    input  logic                 clr_stats,
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 dir_up,
    output logic                 dir_valid,
    output logic [CNT_W-1:0]     step_count,
    output logic [CNT_W-1:0]     wrap_count,
    output logic                 err_illegal,
    output logic                 err_jump,
    output logic                 err_sticky
);

    trk_state_t       state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             dir_up_q, dir_up_d;
    logic             dir_valid_q, dir_valid_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] wrap_q, wrap_d;
    logic             err_ill_q, err_ill_d;
    logic             err_jump_q, err_jump_d;
    logic             sticky_q, sticky_d;
    logic             step_inc, wrap_inc;

    logic             dec_legal;
    logic [3:0]       dec_digit;

    seg7_to_digit #(
        .NBITS_SEG (NBITS_SEG)
    ) u_decode (
        .seg_in (seg_in),
        .legal  (dec_legal),
        .digit  (dec_digit)
    );

    always_comb begin
        state_d     = state_q;
        digit_d     = digit_q;
        dir_up_d    = dir_up_q;
        dir_valid_d = dir_valid_q;
        err_ill_d   = 1'b0;
        err_jump_d  = 1'b0;
        step_inc    = 1'b0;
        wrap_inc    = 1'b0;

        if (seg_valid) begin
            if (!dec_legal) begin
                // Drop tracking but keep the last legal digit visible.
                err_ill_d   = 1'b1;
                dir_valid_d = 1'b0;
                state_d     = EMPTY;
            end else if (state_q == EMPTY) begin
                digit_d     = dec_digit;
                dir_valid_d = 1'b0;
                state_d     = TRACK;
            end else if (dec_digit == digit_q) begin
                state_d = TRACK;
            end else if (dec_digit == inc10(digit_q)) begin
                digit_d     = dec_digit;
                dir_up_d    = 1'b1;
                dir_valid_d = 1'b1;
                step_inc    = 1'b1;
                wrap_inc    = (digit_q == 4'd9);
            end else if (dec_digit == dec10(digit_q)) begin
                digit_d     = dec_digit;
                dir_up_d    = 1'b0;
                dir_valid_d = 1'b1;
                step_inc    = 1'b1;
                wrap_inc    = (digit_q == 4'd0);
            end else begin
                // Resynchronise on the new digit; direction is unknown again.
                digit_d     = dec_digit;
                dir_valid_d = 1'b0;
                err_jump_d  = 1'b1;
            end
        end

        step_d   = step_q;
        wrap_d   = wrap_q;
        sticky_d = sticky_q | err_ill_d | err_jump_d;
        if (clr_stats) begin
            step_d   = '0;
            wrap_d   = '0;
            sticky_d = 1'b0;
        end else begin
            if (step_inc && (step_q != '1)) step_d = step_q + 1'b1;
            if (wrap_inc && (wrap_q != '1)) wrap_d = wrap_q + 1'b1;
        end
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            state_q     <= EMPTY;
            digit_q     <= 4'd0;
            dir_up_q    <= 1'b0;
            dir_valid_q <= 1'b0;
            step_q      <= '0;
            wrap_q      <= '0;
            err_ill_q   <= 1'b0;
            err_jump_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_q     <= digit_d;
            dir_up_q    <= dir_up_d;
            dir_valid_q <= dir_valid_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            err_ill_q   <= err_ill_d;
            err_jump_q  <= err_jump_d;
            sticky_q    <= sticky_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = (state_q == TRACK);
    assign dir_up      = dir_up_q;
    assign dir_valid   = dir_valid_q;
    assign step_count  = step_q;
    assign wrap_count  = wrap_q;
    assign err_illegal = err_ill_q;
    assign err_jump    = err_jump_q;
    assign err_sticky  = sticky_q;

endmodule
